reaction_timer: RTL and testbench



---
 rtl/reaction_pkg.sv | 19 +
 rtl/key_sync_edge.sv | 37 +++
 rtl/reaction_timer.sv | 132 +++++++++++++
 tb/tb_reaction_timer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/reaction_pkg.sv
// reaction_pkg: shared types and constants for the reaction-game timer.
//   RT_W       width of the millisecond counter / result buses
//   RT_MAX_MS  saturation value in ms (fits 14 bits and 4 BCD digits)
//   rt_state_t measurement FSM states
package reaction_pkg;

    localparam int RT_W      = 14;
    localparam int RT_MAX_MS = 9999;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        TIMING,
        DONE,
        FOUL,
        TIMEOUT
    } rt_state_t;

endpackage

// File: rtl/key_sync_edge.sv
// key_sync_edge: brings an asynchronous active-high key into the clk domain
// through a 2-FF synchroniser, then emits a registered one-cycle pulse on
// its rising edge. Holding the key yields exactly one pulse.
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   i_key_raw  asynchronous key level, active-high
//   o_press    one-cycle pulse, 3 clk cycles after the raw rise
module key_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key_raw,
    output logic o_press
);

    logic r_sync1;
    logic r_sync2;
    logic r_sync2_d;
    logic r_press;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_sync2_d <= 1'b0;
            r_press   <= 1'b0;
        end else begin
            r_sync1   <= i_key_raw;
            r_sync2   <= r_sync1;
            r_sync2_d <= r_sync2;
            r_press   <= r_sync2 & ~r_sync2_d;
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/reaction_timer.sv
// reaction_timer: measures whole milliseconds from lights_out to the
// player's key press, detects false starts, saturates at MAX_MS and
// (optionally) tracks the best time since reset.
// Optional feature macro: REACTION_BEST_TIME_EN (best-time record).
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   tick_ms       1 ms enable pulse
//   start         game (re)start pulse, top priority
//   lights_out    pulse from the delay stage
//   react_raw     asynchronous player key, active-high
//   rt_ms         measured time (live while TIMING, held afterwards)
//   rt_valid      high in DONE or TIMEOUT
//   done_pulse    one cycle on entry to DONE, FOUL or TIMEOUT
//   false_start   high in FOUL
//   busy          high in ARMED or TIMING
//   best_ms       lowest valid rt_ms since reset (MAX_MS when disabled)
module reaction_timer
    import reaction_pkg::*;
#(
    parameter int W      = RT_W,
    parameter int MAX_MS = RT_MAX_MS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tick_ms,
    input  logic         start,
    input  logic         lights_out,
    input  logic         react_raw,
    output logic [W-1:0] rt_ms,
    output logic         rt_valid,
    output logic         done_pulse,
    output logic         false_start,
    output logic         busy,
    output logic [W-1:0] best_ms
);

    localparam logic [W-1:0] MAX_V = W'(MAX_MS);

    logic         w_press;
    rt_state_t    r_state, w_nxt_state;
    logic [W-1:0] r_cnt, w_nxt_cnt;
    logic         r_done_pulse, w_nxt_pulse;
    logic         r_valid, r_foul, r_busy;

    key_sync_edge u_key (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_key_raw (react_raw),
        .o_press   (w_press)
    );

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_pulse = 1'b0;
        if (start) begin
            w_nxt_state = ARMED;
            w_nxt_cnt   = '0;
        end else begin
            case (r_state)
                ARMED: begin
                    // A press coincident with lights_out is still early.
                    if (w_press) begin
                        w_nxt_state = FOUL;
                        w_nxt_pulse = 1'b1;
                    end else if (lights_out) begin
                        w_nxt_state = TIMING;
                        w_nxt_cnt   = '0;
                    end
                end
                TIMING: begin
                    // Press wins over a same-cycle tick: that tick is not counted.
                    if (w_press) begin
                        w_nxt_state = DONE;
                        w_nxt_pulse = 1'b1;
                    end else if (tick_ms) begin
                        if (r_cnt == MAX_V) begin
                            w_nxt_state = TIMEOUT;
                            w_nxt_pulse = 1'b1;
                        end else begin
                            w_nxt_cnt = r_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Flag outputs are registered from the next state so they change in
    // the same cycle the new state becomes visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_done_pulse <= 1'b0;
            r_valid      <= 1'b0;
            r_foul       <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_cnt        <= w_nxt_cnt;
            r_done_pulse <= w_nxt_pulse;
            r_valid      <= (w_nxt_state == DONE) || (w_nxt_state == TIMEOUT);
            r_foul       <= (w_nxt_state == FOUL);
            r_busy       <= (w_nxt_state == ARMED) || (w_nxt_state == TIMING);
        end
    end

`ifdef REACTION_BEST_TIME_EN
    logic [W-1:0] r_best;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_best <= MAX_V;
        end else if (!start && r_state == TIMING && w_press && r_cnt < r_best) begin
            r_best <= r_cnt;
        end
    end

    assign best_ms = r_best;
`else
    assign best_ms = MAX_V;
`endif

    assign rt_ms       = r_cnt;
    assign rt_valid    = r_valid;
    assign done_pulse  = r_done_pulse;
    assign false_start = r_foul;
    assign busy        = r_busy;

endmodule

// File: tb/tb_reaction_timer.sv
module tb_reaction_timer;

    localparam int W = 14;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         tick_ms, start, lights_out, react_raw;
    logic [W-1:0] rt_ms, best_ms;
    logic         rt_valid, done_pulse, false_start, busy;

    int total = 0;
    int bad   = 0;
    int npulse;

    reaction_timer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick_ms     (tick_ms),
        .start       (start),
        .lights_out  (lights_out),
        .react_raw   (react_raw),
        .rt_ms       (rt_ms),
        .rt_valid    (rt_valid),
        .done_pulse  (done_pulse),
        .false_start (false_start),
        .busy        (busy),
        .best_ms     (best_ms)
    );

    always #5 clk = ~clk;

    function automatic int exp_best(input int v);
`ifdef REACTION_BEST_TIME_EN
        return v;
`else
        return 9999;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start;
        start = 1'b1; step; start = 1'b0;
    endtask

    task automatic do_lights;
        lights_out = 1'b1; step; lights_out = 1'b0;
    endtask

    // tick_ms high for n consecutive edges
    task automatic do_ticks(input int n);
        tick_ms = 1'b1;
        repeat (n) step;
        tick_ms = 1'b0;
    endtask

    // Raise the key and count done pulses over a bounded window.
    task automatic press_key(output int pulses);
        pulses = 0;
        react_raw = 1'b1;
        repeat (8) begin
            step;
            if (done_pulse === 1'b1) pulses++;
        end
    endtask

    task automatic release_key;
        react_raw = 1'b0;
        repeat (4) step;
    endtask

    task automatic round(input int ms, input int best, input string tag);
        do_start;
        do_lights;
        do_ticks(ms);
        press_key(npulse);
        chk({tag, "_pulses"}, npulse, 1);
        chk({tag, "_rt"}, rt_ms, ms);
        chk({tag, "_best"}, best_ms, exp_best(best));
    endtask

    initial begin
        rst_n = 1'b0; tick_ms = 1'b0; start = 1'b0; lights_out = 1'b0; react_raw = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rt", rt_ms, 0);
        chk("rst_valid", rt_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_best", best_ms, 9999);
        rst_n = 1'b1;
        step;

        // IDLE ignores lights_out
        do_lights;
        chk("idle_busy", busy, 0);

        // basic 237 ms measurement
        do_start;
        chk("armed_busy", busy, 1);
        do_lights;
        do_ticks(237);
        chk("live_rt", rt_ms, 237);
        press_key(npulse);
        chk("m237_pulses", npulse, 1);
        chk("m237_rt", rt_ms, 237);
        chk("m237_valid", rt_valid, 1);
        chk("m237_busy", busy, 0);
        chk("m237_best", best_ms, exp_best(237));
        do_ticks(5);
        chk("done_hold", rt_ms, 237);
        release_key;

        // false start, later lights_out ignored
        do_start;
        chk("fs_start_rt", rt_ms, 0);
        press_key(npulse);
        chk("fs_pulses", npulse, 1);
        chk("fs_flag", false_start, 1);
        chk("fs_rt", rt_ms, 0);
        do_lights;
        do_ticks(3);
        chk("fs_hold_flag", false_start, 1);
        chk("fs_hold_busy", busy, 0);
        chk("fs_hold_valid", rt_valid, 0);
        release_key;

        // press coincident with a tick: tick not counted
        do_start;
        do_lights;
        tick_ms = 1'b1;
        repeat (97) step;
        react_raw = 1'b1;
        repeat (4) step;
        tick_ms = 1'b0;
        chk("align_pulse", done_pulse, 1);
        chk("align_rt", rt_ms, 100);
        chk("align_best", best_ms, exp_best(100));
        step;
        chk("align_pulse_end", done_pulse, 0);
        release_key;

        // press coincident with lights_out in ARMED -> FOUL
        do_start;
        react_raw = 1'b1;
        repeat (3) step;
        lights_out = 1'b1;
        step;
        lights_out = 1'b0;
        chk("armlo_foul", false_start, 1);
        chk("armlo_pulse", done_pulse, 1);
        chk("armlo_busy", busy, 0);
        release_key;

        // saturation / timeout
        do_start;
        do_lights;
        do_ticks(9999);
        chk("sat_pre_rt", rt_ms, 9999);
        chk("sat_pre_busy", busy, 1);
        do_ticks(1);
        chk("to_pulse", done_pulse, 1);
        chk("to_rt", rt_ms, 9999);
        chk("to_valid", rt_valid, 1);
        chk("to_best", best_ms, exp_best(100));
        do_ticks(3);
        chk("to_hold", rt_ms, 9999);

        // asynchronous reset mid-TIMING
        do_start;
        do_lights;
        do_ticks(55);
        chk("pre_rst_rt", rt_ms, 55);
        rst_n = 1'b0;
        #2;
        chk("arst_rt", rt_ms, 0);
        chk("arst_busy", busy, 0);
        chk("arst_valid", rt_valid, 0);
        chk("arst_best", best_ms, 9999);
        step;
        rst_n = 1'b1;
        step;

        // best-time rounds; key held across a start gives no second press
        round(300, 300, "r1");
        do_start;
        repeat (6) step;
        chk("held_busy", busy, 1);
        chk("held_foul", false_start, 0);
        release_key;
        do_lights;
        do_ticks(180);
        press_key(npulse);
        chk("r2_pulses", npulse, 1);
        chk("r2_rt", rt_ms, 180);
        chk("r2_best", best_ms, exp_best(180));
        release_key;
        round(250, 180, "r3");
        do_start;
        chk("restart_rt", rt_ms, 0);
        chk("restart_valid", rt_valid, 0);
        chk("restart_best", best_ms, exp_best(180));
        release_key;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
